// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC rate-change controller.
package cic_pkg;

    // Rate words are widened to this before range checks so any RATE_DW up to 64 compares cleanly.
    localparam int unsigned RateCmpW = 64;

    typedef enum logic [2:0] {
        StInit,
        StRun,
        StDrain,
        StApply,
        StSettle
    } cic_rate_ctrl_state_t;

    function automatic logic rate_in_range(input logic [RateCmpW-1:0] r,
                                           input logic [RateCmpW-1:0] cic_r);
        return (r != '0) && (r <= cic_r);
    endfunction

endpackage

// File: rtl/cic_down_counter.sv
// Loadable down-counter that saturates at zero; flags zero and the final count.
module cic_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);
    assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/cic_rate_ctrl.sv
// Run-time decimation-rate controller: validates requests, drains the integrators,
// issues the rate update, then masks filter output until the combs have settled.
module cic_rate_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned RATE_DW      = 32,
    parameter int unsigned OUT_DW       = 32,
    parameter int unsigned CIC_R        = 10,
    parameter int unsigned CIC_N        = 7,
    parameter int unsigned CIC_M        = 1,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
    input  logic               s_axis_cfg_tvalid,
    output logic               s_axis_cfg_tready,
    output logic               s_axis_in_tready,
    output logic [RATE_DW-1:0] cic_rate_tdata,
    output logic               cic_rate_tvalid,
    input  logic [OUT_DW-1:0]  cic_out_tdata,
    input  logic               cic_out_tvalid,
    output logic [OUT_DW-1:0]  m_axis_out_tdata,
    output logic               m_axis_out_tvalid,
    output logic [RATE_DW-1:0] current_rate,
    output logic               cfg_error
);

    localparam int unsigned DrainW  = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned SettleW = $clog2(CIC_N * CIC_M + 1);

    cic_rate_ctrl_state_t state_q, state_d;

    logic [RATE_DW-1:0] pending_q;
    logic [RATE_DW-1:0] current_rate_q;
    logic               cfg_error_q;
    logic [OUT_DW-1:0]  out_data_q;
    logic               out_valid_q;

    logic cfg_tready, in_tready, rate_tvalid, mask;
    logic cfg_hs, req_ok, req_new, req_bad;
    logic drain_zero, drain_last, settle_zero, settle_last;

    assign cfg_hs  = s_axis_cfg_tvalid && cfg_tready;
    assign req_ok  = rate_in_range(RateCmpW'(s_axis_cfg_tdata), RateCmpW'(CIC_R));
    assign req_new = cfg_hs && req_ok && (s_axis_cfg_tdata != current_rate_q);
    assign req_bad = cfg_hs && !req_ok;

    cic_down_counter #(
        .WIDTH (DrainW)
    ) u_drain_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (req_new),
        .load_value (DrainW'(DRAIN_CYCLES)),
        .dec        (state_q == StDrain),
        .zero       (drain_zero),
        .last       (drain_last)
    );

    cic_down_counter #(
        .WIDTH (SettleW)
    ) u_settle_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (state_q == StApply),
        .load_value (SettleW'(CIC_N * CIC_M)),
        .dec        ((state_q == StSettle) && cic_out_tvalid),
        .zero       (settle_zero),
        .last       (settle_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   state_d = StRun;
            StRun:    if (req_new) state_d = StDrain;
            StDrain:  if (drain_last || drain_zero) state_d = StApply;
            StApply:  state_d = StSettle;
            StSettle: if (settle_zero || (cic_out_tvalid && settle_last)) state_d = StRun;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        cfg_tready  = 1'b0;
        in_tready   = 1'b0;
        rate_tvalid = 1'b0;
        mask        = 1'b0;
        unique case (state_q)
            StRun: begin
                cfg_tready = 1'b1;
                in_tready  = 1'b1;
            end
            StApply:  rate_tvalid = 1'b1;
            StSettle: begin
                in_tready = 1'b1;
                mask      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q      <= RATE_DW'(CIC_R);
            current_rate_q <= RATE_DW'(CIC_R);
            cfg_error_q    <= 1'b0;
        end else begin
            cfg_error_q <= req_bad;
            if (req_new) begin
                pending_q <= s_axis_cfg_tdata;
            end
            if (state_q == StApply) begin
                current_rate_q <= pending_q;
            end
        end
    end

    // Samples leaving the filter while the combs still hold old-rate history are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (cic_out_tvalid && !mask) begin
            out_data_q  <= cic_out_tdata;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign s_axis_cfg_tready = cfg_tready;
    assign s_axis_in_tready  = in_tready;
    assign cic_rate_tdata    = pending_q;
    assign cic_rate_tvalid   = rate_tvalid;
    assign m_axis_out_tdata  = out_data_q;
    assign m_axis_out_tvalid = out_valid_q;
    assign current_rate      = current_rate_q;
    assign cfg_error         = cfg_error_q;

endmodule
